// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer controller.
// Holds default widths, named datapath register IDs and the FSM state encoding.
// Optional feature macro used by the design: BUS_XFER_IMM_EN (immediate-sourced moves).
package bus_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned NUM_REGS_DEF = 8;
    localparam int unsigned ID_W_DEF     = 3;

    // Datapath register IDs on the shared bus
    localparam logic [ID_W_DEF-1:0] REG_AC   = 3'd0;
    localparam logic [ID_W_DEF-1:0] REG_DR   = 3'd1;
    localparam logic [ID_W_DEF-1:0] REG_IR   = 3'd2;
    localparam logic [ID_W_DEF-1:0] REG_TR   = 3'd3;
    localparam logic [ID_W_DEF-1:0] REG_AR   = 3'd4;
    localparam logic [ID_W_DEF-1:0] REG_PC   = 3'd5;
    localparam logic [ID_W_DEF-1:0] REG_OUTR = 3'd6;
    localparam logic [ID_W_DEF-1:0] REG_INPR = 3'd7;

    // Move sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Command and register-bus signal bundle for bus_xfer_ctrl.
// master: the transfer controller (drives cmd_ready, strobes, bus_out, done, err).
// slave : control unit plus register file (drives command fields and reg_rdata).
// cmd_imm_sel/cmd_imm exist only when BUS_XFER_IMM_EN is defined.
interface bus_xfer_ctrl_if #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ID_W     = 3
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [ID_W-1:0]            cmd_src;
    logic [ID_W-1:0]            cmd_dst;
`ifdef BUS_XFER_IMM_EN
    logic                       cmd_imm_sel;
    logic [DATA_W-1:0]          cmd_imm;
`endif
    logic [NUM_REGS-1:0]        rd_en;
    logic [NUM_REGS*DATA_W-1:0] reg_rdata;
    logic [DATA_W-1:0]          bus_out;
    logic [NUM_REGS-1:0]        wr_en;
    logic                       done;
    logic                       err;

    modport master (
        input  cmd_valid, cmd_src, cmd_dst, reg_rdata,
`ifdef BUS_XFER_IMM_EN
        input  cmd_imm_sel, cmd_imm,
`endif
        output cmd_ready, rd_en, bus_out, wr_en, done, err
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, reg_rdata,
`ifdef BUS_XFER_IMM_EN
        output cmd_imm_sel, cmd_imm,
`endif
        input  cmd_ready, rd_en, bus_out, wr_en, done, err
    );
endinterface

// File: rtl/bus_src_mux.sv
// Combinational NUM_REGS:1 select of register read data by register ID.
// sel_i     : register ID
// rdata_i   : flattened register outputs, reg k at [k*DATA_W +: DATA_W]
// data_c_o  : selected register value (zero for an ID with no register)
module bus_src_mux
    import bus_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ID_W     = ID_W_DEF
) (
    input  logic [ID_W-1:0]            sel_i,
    input  logic [NUM_REGS*DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0]          data_c_o
);

    always_comb begin
        data_c_o = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (sel_i == ID_W'(k)) data_c_o = rdata_i[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus-side master for the datapath registers: sequences a register-to-register
// move as Read strobe -> capture out_bus -> drive in_bus -> Write strobe.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus_if   : bus_xfer_ctrl_if.master (command handshake, rd_en/wr_en strobes,
//              reg_rdata fan-in, bus_out drive, done/err pulses)
// Macro BUS_XFER_IMM_EN adds immediate-sourced moves that skip the read phase.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ID_W     = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bus_xfer_ctrl_if.master  bus_if
);

    localparam int unsigned  CNT_W       = ID_W + 1;
    localparam logic [ID_W:0] NUM_REGS_ID = CNT_W'(NUM_REGS);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     src_q, src_d, dst_q, dst_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] rd_en_q, rd_en_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;

    logic [DATA_W-1:0]   src_rdata_c;
    logic                accept_c;
    logic                src_bad_c;
    logic                dst_bad_c;
    logic                cmd_ok_c;
    logic                imm_c;

    function automatic logic [NUM_REGS-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (id == ID_W'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Latched source ID drives the read-data select so input changes mid-move are harmless
    bus_src_mux #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ID_W     (ID_W)
    ) u_src_mux (
        .sel_i    (src_q),
        .rdata_i  (bus_if.reg_rdata),
        .data_c_o (src_rdata_c)
    );

    // Command acceptance and ID validation
    always_comb begin
        accept_c  = (state_q == ST_IDLE) && cmd_ready_q && bus_if.cmd_valid;
        src_bad_c = {1'b0, bus_if.cmd_src} >= NUM_REGS_ID;
        dst_bad_c = {1'b0, bus_if.cmd_dst} >= NUM_REGS_ID;
`ifdef BUS_XFER_IMM_EN
        imm_c     = bus_if.cmd_imm_sel;
`else
        imm_c     = 1'b0;
`endif
        // Immediate moves never read a register, so only dst is checked for them
        cmd_ok_c  = imm_c ? !dst_bad_c : !(src_bad_c || dst_bad_c);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= '0;
            wr_en_q     <= '0;
            bus_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            bus_out_q   <= bus_out_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    src_d = bus_if.cmd_src;
                    dst_d = bus_if.cmd_dst;
                    if (cmd_ok_c) state_d = imm_c ? ST_WR : ST_RD;
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_WR;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; strobes are one-cycle pulses derived from the state entered
    always_comb begin
        rd_en_d     = '0;
        wr_en_d     = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_out_d   = bus_out_q;
        cmd_ready_d = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (!cmd_ok_c) begin
                        err_d = 1'b1;
                    end else if (imm_c) begin
`ifdef BUS_XFER_IMM_EN
                        bus_out_d = bus_if.cmd_imm;
`endif
                        wr_en_d   = id_onehot(bus_if.cmd_dst);
                    end else begin
                        rd_en_d   = id_onehot(bus_if.cmd_src);
                    end
                end
            end
            ST_CAP: begin
                bus_out_d = src_rdata_c;
                wr_en_d   = id_onehot(dst_q);
            end
            ST_WR:   done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus_if.cmd_ready = cmd_ready_q;
    assign bus_if.rd_en     = rd_en_q;
    assign bus_if.wr_en     = wr_en_q;
    assign bus_if.bus_out   = bus_out_q;
    assign bus_if.done      = done_q;
    assign bus_if.err       = err_q;

endmodule
